pixel_sink_scanout: RTL and testbench
=====================================

Name: pixel_sink_scanout

Overview:
- Consumer end of the pixel-write interface (plot, x, y, colour) driven by the sprite draw/erase datapaths.
- Stores each accepted write into a 160x120, 3-bit-per-pixel frame memory.
- Continuously reads that memory out as 640x480@60 VGA: 25 MHz pixel enable derived from the 50 MHz clock, each stored pixel replicated 4x4.
- Sits between the game datapaths and the board DAC/sync pins.

Parameters:
- FB_W, 160, frame buffer width in pixels
- FB_H, 120, frame buffer height in pixels
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SW, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SW, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- plot  in  1  write strobe, one pixel per cycle while high
- x  in  8  write column
- y  in  8  write row
- colour  in  3  {R,G,B} write data
- busy  out  1  high while writes are being ignored (clear sweep)
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during visible region
- vga_pix_en  out  1  pixel-clock enable / DAC clock

Behaviour:
- Reset (async, reset_n=0) sets:
  - pix_en=0, h_cnt=0, v_cnt=0.
  - vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0.
  - busy=1 if FB_CLEAR_EN is defined, else 0.
- Pixel enable:
  - pix_en toggles every clk.
  - Counters advance only on edges where pix_en=1; the first increment is at the 2nd clk edge after reset release.
- Horizontal and vertical counters:
  - h_cnt counts 0..799 and wraps to 0.
  - On the h_cnt 799->0 wrap, v_cnt advances 0..524 and wraps to 0.
- Sync and blank decode from counters:
  - hs_raw=0 for h_cnt in [656,751].
  - vs_raw=0 for v_cnt in [490,491].
  - blank_raw_n=1 iff h_cnt<640 and v_cnt<480.
- Read path:
  - Read address = (v_cnt>>2)*FB_W + (h_cnt>>2), 15 bits.
  - Memory read is synchronous, 1 clk.
- Output alignment:
  - Sync, blank and colour outputs are registered and mutually aligned.
  - All outputs reflect counter state delayed by exactly one pixel period (2 clk).
  - Colour expansion: vga_r={8{c[2]}}, vga_g={8{c[1]}}, vga_b={8{c[0]}}.
  - All three colour buses are forced to 0 when the aligned blank_n=0.
- Write acceptance:
  - A write is accepted on a clk edge with plot=1, busy=0, x<FB_W and y<FB_H.
  - Accepted writes store colour at y*FB_W+x; writes are never back-pressured.
  - Out-of-range coordinates are silently dropped, with no wrap or alias.
- Read/write collision:
  - The memory is dual-port.
  - A same-cycle read and write to one address returns the old data.
  - The new value is visible on the next frame.
- Reset mid-frame: counters and outputs return to reset values immediately; memory contents are undisturbed unless FB_CLEAR_EN is defined.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined: a two-state FSM, CLEAR then RUN, entered from reset.
  - CLEAR: writes 3'b000 to addresses 0..FB_W*FB_H-1, one per clk; busy=1; plot ignored.
  - The last clear write (address 19199) occurs on the 19200th edge after reset release; busy falls on that same edge.
  - RUN: busy=0; stays in RUN until reset.
  - Scan-out runs during CLEAR.
- Undefined: no FSM; busy tied 0; memory powers up undefined.

Test Plan:
- Reset release, no writes -> first vga_hs falling edge 2*(656+1) clk after release; hs low for exactly 192 clk; line period 1600 clk; vs low for 2 lines (3200 clk) per 525-line frame.
- plot=1, x=0, y=0, colour=3'b100 -> during first visible 4x4 block of next frame vga_r=8'hFF, vga_g=vga_b=0, blank_n=1; pixel at h=4 shows prior contents.
- plot=1, x=8'd160, y=8'd10, colour=3'b111 -> no memory change; read of (159,10) and (0,11) unchanged.
- Write x=159, y=119, colour=3'b011 -> bottom-right 4x4 block (h 636..639, v 476..479) shows g=b=8'hFF, r=0; h=640 shows rgb=0, blank_n=0.
- Assert reset_n=0 mid-line (h_cnt~300) -> vga_hs=1, vga_vs=1, blank_n=0, rgb=0 without clk edge; previously written pixel still displayed after release.
- FB_CLEAR_EN defined: busy=1 for 19200 clk after release; plot ignored meanwhile; every pixel then reads 3'b000; a write one cycle after busy falls is stored.

Source files
------------

// File: rtl/pixel_sink_scanout_if.sv
// rtl/pixel_sink_scanout_if.sv - pixel-write bus between the sprite datapaths and the frame-buffer sink
//
// Signals:
//   plot    write strobe, one pixel per cycle while high
//   x, y    write column / row
//   colour  {R,G,B} write data
//   busy    sink is ignoring writes (frame-buffer clear in progress)
// Modports: master = draw datapath, slave = pixel_sink_scanout.
interface pixel_sink_scanout_if;
  logic       plot;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       busy;

  modport master (output plot, x, y, colour, input busy);
  modport slave  (input plot, x, y, colour, output busy);
endinterface

// File: rtl/pixel_sink_scanout.sv
// rtl/pixel_sink_scanout.sv - 160x120x3 frame buffer with 640x480@60 VGA scan-out
//
// Purpose: accepts pixel writes from the draw datapaths into a dual-port frame
// memory and scans it out as VGA with each stored pixel replicated 4x4.
// Optional build macro: FB_CLEAR_EN (clear sweep of the frame buffer after reset).
//
// Ports:
//   clk          50 MHz system clock
//   reset_n      asynchronous active-low reset
//   wr           pixel-write bus (slave side: plot, x, y, colour in; busy out)
//   vga_r/g/b    8-bit colour, zero outside the visible region
//   vga_hs/vs    active-low syncs
//   vga_blank_n  high in the visible region
//   vga_pix_en   25 MHz pixel enable / DAC clock
module pixel_sink_scanout #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pixel_sink_scanout_if.slave   wr,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_blank_n,
  output logic                  vga_pix_en
);

  localparam int FB_N = FB_W * FB_H;
  localparam int AW   = $clog2(FB_N);

  localparam logic [9:0]  L_H_LAST  = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0]  L_V_LAST  = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0]  L_HS_ON   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  L_HS_OFF  = 10'(H_VIS + H_FP + H_SW - 1);
  localparam logic [9:0]  L_VS_ON   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  L_VS_OFF  = 10'(V_VIS + V_FP + V_SW - 1);
  localparam logic [9:0]  L_H_VIS   = 10'(H_VIS);
  localparam logic [9:0]  L_V_VIS   = 10'(V_VIS);
  localparam logic [14:0] L_FB_W15  = 15'(FB_W);
  localparam logic [14:0] L_FB_N15  = 15'(FB_N);

  // ---------------- pixel enable and raster counters ----------------
  logic       r_pix_en;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_en <= 1'b0;
      r_h_cnt  <= 10'd0;
      r_v_cnt  <= 10'd0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_h_cnt == L_H_LAST) begin
          r_h_cnt <= 10'd0;
          r_v_cnt <= (r_v_cnt == L_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  assign vga_pix_en = r_pix_en;

  logic w_hs_raw;
  logic w_vs_raw;
  logic w_blank_raw_n;

  assign w_hs_raw      = !((r_h_cnt >= L_HS_ON) && (r_h_cnt <= L_HS_OFF));
  assign w_vs_raw      = !((r_v_cnt >= L_VS_ON) && (r_v_cnt <= L_VS_OFF));
  assign w_blank_raw_n = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);

  // ---------------- clear sweep / write arbitration ----------------
  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

`ifdef FB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [AW-1:0] L_CLR_LAST = AW'(FB_N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // busy is decoded from state so it drops on the same edge as the last clear write.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = 1'b1;
        if (r_clr_addr == L_CLR_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_clr_addr = r_clr_addr;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign wr.busy = w_busy;

  // Range-check before forming the address so out-of-range writes never alias.
  logic          w_wr_ok;
  logic [AW-1:0] w_plot_addr;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [2:0]    w_wdata;

  assign w_wr_ok     = wr.plot && !w_busy &&
                       ({1'b0, wr.x} < 9'(FB_W)) && ({1'b0, wr.y} < 9'(FB_H));
  assign w_plot_addr = AW'(wr.y) * AW'(FB_W) + AW'(wr.x);
  assign w_we        = w_clr_we || w_wr_ok;
  assign w_waddr     = w_clr_we ? w_clr_addr : w_plot_addr;
  assign w_wdata     = w_clr_we ? 3'b000 : wr.colour;

  // ---------------- frame memory ----------------
  // Addresses past the buffer occur only during blanking; steer them to 0
  // since their data is masked at the output anyway.
  logic [14:0]   w_rd_addr;
  logic [AW-1:0] w_rd_idx;
  logic [2:0]    r_mem [FB_N];
  logic [2:0]    r_rd_data;

  assign w_rd_addr = 15'(r_v_cnt[9:2]) * L_FB_W15 + 15'(r_h_cnt[9:2]);
  assign w_rd_idx  = (w_rd_addr < L_FB_N15) ? w_rd_addr[AW-1:0] : '0;

  // Same-address read and write return the old contents.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd_data <= r_mem[w_rd_idx];
  end

  // ---------------- aligned output registers ----------------
  // Updated on the enable edge: the counters still hold the value whose memory
  // word was fetched on the previous (non-enable) edge, giving a 2-clk delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (r_pix_en) begin
      vga_hs      <= w_hs_raw;
      vga_vs      <= w_vs_raw;
      vga_blank_n <= w_blank_raw_n;
      vga_r       <= w_blank_raw_n ? {8{r_rd_data[2]}} : 8'h00;
      vga_g       <= w_blank_raw_n ? {8{r_rd_data[1]}} : 8'h00;
      vga_b       <= w_blank_raw_n ? {8{r_rd_data[0]}} : 8'h00;
    end
  end

endmodule

// File: tb/tb_pixel_sink_scanout.sv
// tb/tb_pixel_sink_scanout.sv - directed self-checking bench for pixel_sink_scanout
module tb_pixel_sink_scanout;

  // Reduced-geometry instance: 16x8 buffer shown as 64x32, 80x39 raster.
  localparam int SW     = 16;
  localparam int SH     = 8;
  localparam int SHT    = 80;
  localparam int SVT    = 39;
  localparam int SFRAME = SHT * SVT;

`ifdef FB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int ec     = 0;
  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] model [SW*SH];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;

  pixel_sink_scanout_if wf ();
  pixel_sink_scanout_if ws ();

  logic [7:0] f_r, f_g, f_b, s_r, s_g, s_b;
  logic f_hs, f_vs, f_blank_n, f_pix_en, s_hs, s_vs, s_blank_n, s_pix_en;
  logic [24:0] s_obs;
  assign s_obs = {s_blank_n, s_r, s_g, s_b};

  pixel_sink_scanout u_full (
    .clk(clk), .reset_n(rst_n), .wr(wf),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hs(f_hs), .vga_vs(f_vs),
    .vga_blank_n(f_blank_n), .vga_pix_en(f_pix_en)
  );

  pixel_sink_scanout #(
    .FB_W(16), .FB_H(8), .H_VIS(64), .H_FP(4), .H_SW(8), .H_BP(4),
    .V_VIS(32), .V_FP(2), .V_SW(2), .V_BP(3)
  ) u_small (
    .clk(clk), .reset_n(rst_n), .wr(ws),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_blank_n), .vga_pix_en(s_pix_en)
  );

  function automatic logic [24:0] px(input logic [2:0] c);
    return {1'b1, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  function automatic int pos(input int h, input int v, input int f);
    return f * SFRAME + v * SHT + h;
  endfunction

  function automatic int next_frame();
    return (ec / 2) / SFRAME + 1;
  endfunction

  task automatic wait_ec(input int n);
    while (ec < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Small-instance outputs show raster position p after edge 2*(p+1).
  task automatic goto_pos(input int p);
    if (ec > 2 * (p + 1)) begin
      n_chk++;
      $display("FAIL goto_pos: ec %0d already past target %0d", ec, 2 * (p + 1));
    end else begin
      wait_ec(2 * (p + 1));
    end
  endtask

  task automatic wr_px(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    @(negedge clk);
    ws.plot = 1'b1; ws.x = x; ws.y = y; ws.colour = c;
    @(negedge clk);
    ws.plot = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ws.plot = 1'b0; ws.x = 8'd0; ws.y = 8'd0; ws.colour = 3'd0;
    wf.plot = 1'b0; wf.x = 8'd0; wf.y = 8'd0; wf.colour = 3'd0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({s_hs, s_vs, s_blank_n, s_r, s_g, s_b} !== {3'b110, 24'h0})
      $display("FAIL reset_small_out: got %h want %h", {s_hs, s_vs, s_blank_n, s_r, s_g, s_b}, {3'b110, 24'h0});
    else n_pass++;
    n_chk++;
    if ({f_hs, f_vs, f_blank_n, f_r, f_g, f_b} !== {3'b110, 24'h0})
      $display("FAIL reset_full_out: got %h want %h", {f_hs, f_vs, f_blank_n, f_r, f_g, f_b}, {3'b110, 24'h0});
    else n_pass++;
    n_chk++;
    if ({s_pix_en, f_pix_en} !== 2'b00) $display("FAIL reset_pix_en: got %b want 00", {s_pix_en, f_pix_en});
    else n_pass++;
    n_chk++;
    if ({ws.busy, wf.busy} !== {BUSY_RST, BUSY_RST})
      $display("FAIL reset_busy: got %b want %b", {ws.busy, wf.busy}, {BUSY_RST, BUSY_RST});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_sync_timing;
    int hf1 = -1, hr1 = -1, hf2 = -1, shf = -1, vf1 = -1, vr1 = -1, vf2 = -1;
    logic phs = 1'b1, pshs = 1'b1, pvs = 1'b1;
    while (ec < 11800) begin
      @(posedge clk);
      #1;
      if (phs && !f_hs) begin
        if (hf1 < 0) hf1 = ec; else if (hf2 < 0) hf2 = ec;
      end
      if (!phs && f_hs && hr1 < 0) hr1 = ec;
      if (pshs && !s_hs && shf < 0) shf = ec;
      if (pvs && !s_vs) begin
        if (vf1 < 0) vf1 = ec; else if (vf2 < 0) vf2 = ec;
      end
      if (!pvs && s_vs && vr1 < 0) vr1 = ec;
      phs = f_hs; pshs = s_hs; pvs = s_vs;
    end
    n_chk++; if (hf1 !== 1314) $display("FAIL hs_first_fall: got %0d want 1314", hf1); else n_pass++;
    n_chk++; if (hr1 - hf1 !== 192) $display("FAIL hs_low_width: got %0d want 192", hr1 - hf1); else n_pass++;
    n_chk++; if (hf2 - hf1 !== 1600) $display("FAIL line_period: got %0d want 1600", hf2 - hf1); else n_pass++;
    n_chk++; if (shf !== 138) $display("FAIL small_hs_fall: got %0d want 138", shf); else n_pass++;
    n_chk++; if (vf1 !== 5442) $display("FAIL vs_first_fall: got %0d want 5442", vf1); else n_pass++;
    n_chk++; if (vr1 - vf1 !== 320) $display("FAIL vs_low_width: got %0d want 320", vr1 - vf1); else n_pass++;
    n_chk++; if (vf2 - vf1 !== 6240) $display("FAIL frame_period: got %0d want 6240", vf2 - vf1); else n_pass++;
  endtask

  task automatic fill_pattern;
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++) begin
        logic [2:0] c;
        c = 3'((x * 3 + y * 5) & 7);
        wr_px(8'(x), 8'(y), c);
        model[y * SW + x] = c;
      end
  endtask

  task automatic test_write_origin;
    int f;
    wr_px(8'd0, 8'd0, 3'b100);
    model[0] = 3'b100;
    f = next_frame();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 5; h++) begin
        if (h == 4 && v != 0) continue;
        goto_pos(pos(h, v, f));
        n_chk++;
        if (s_obs !== px(model[h / 4]))
          $display("FAIL origin_block h=%0d v=%0d: got %h want %h", h, v, s_obs, px(model[h / 4]));
        else n_pass++;
      end
  endtask

  task automatic test_out_of_range;
    int f;
    wr_px(8'd16, 8'd2, 3'b010);
    f = next_frame();
    goto_pos(pos(60, 8, f));
    n_chk++;
    if (s_obs !== px(model[2 * SW + 15])) $display("FAIL oor_last_col: got %h want %h", s_obs, px(model[2 * SW + 15]));
    else n_pass++;
    goto_pos(pos(0, 12, f));
    n_chk++;
    if (s_obs !== px(model[3 * SW])) $display("FAIL oor_no_alias: got %h want %h", s_obs, px(model[3 * SW]));
    else n_pass++;
  endtask

  task automatic test_bottom_right;
    int f;
    logic [24:0] exp_v;
    wr_px(8'd15, 8'd7, 3'b011);
    model[7 * SW + 15] = 3'b011;
    f = next_frame();
    for (int v = 28; v < 32; v++)
      for (int h = 60; h < 65; h++) begin
        exp_v = (h == 64) ? 25'h0 : {1'b1, 8'h00, 8'hFF, 8'hFF};
        goto_pos(pos(h, v, f));
        n_chk++;
        if (s_obs !== exp_v) $display("FAIL bottom_right h=%0d v=%0d: got %h want %h", h, v, s_obs, exp_v);
        else n_pass++;
      end
  endtask

  task automatic test_collision;
    int f, p;
    logic [2:0] old_c;
    f = next_frame();
    p = pos(20, 20, f);
    old_c = model[5 * SW + 5];
    goto_pos(p - 1);
    wr_px(8'd5, 8'd5, 3'b110);
    model[5 * SW + 5] = 3'b110;
    goto_pos(p);
    n_chk++;
    if (s_obs !== px(old_c)) $display("FAIL collision_old: got %h want %h", s_obs, px(old_c));
    else n_pass++;
    goto_pos(p + 1);
    n_chk++;
    if (s_obs !== px(3'b110)) $display("FAIL collision_after: got %h want %h", s_obs, px(3'b110));
    else n_pass++;
    goto_pos(pos(20, 20, f + 1));
    n_chk++;
    if (s_obs !== px(3'b110)) $display("FAIL collision_next_frame: got %h want %h", s_obs, px(3'b110));
    else n_pass++;
  endtask

  task automatic test_reset_midline;
    int f;
    f = next_frame();
    goto_pos(pos(30, 1, f));
    n_chk++;
    if (s_obs !== px(model[7])) $display("FAIL midline_pre: got %h want %h", s_obs, px(model[7]));
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_pix_en} !== {3'b110, 24'h0, 1'b0})
      $display("FAIL midline_async_reset: got %h want %h", {s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_pix_en}, {3'b110, 24'h0, 1'b0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef FB_CLEAR_EN
    for (int i = 0; i < SW * SH; i++) model[i] = 3'b000;
`endif
    goto_pos(pos(0, 0, 1));
    n_chk++;
    if (s_obs !== px(model[0])) $display("FAIL midline_mem_kept: got %h want %h", s_obs, px(model[0]));
    else n_pass++;
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ec(40);
    wr_px(8'd2, 8'd0, 3'b111);
    wait_ec(127);
    n_chk++; if (ws.busy !== 1'b1) $display("FAIL clear_busy_127: got %b want 1", ws.busy); else n_pass++;
    wait_ec(128);
    n_chk++; if (ws.busy !== 1'b0) $display("FAIL clear_busy_128: got %b want 0", ws.busy); else n_pass++;
    wr_px(8'd1, 8'd0, 3'b101);
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++) begin
        logic [2:0] c;
        c = (x == 1 && y == 0) ? 3'b101 : 3'b000;
        goto_pos(pos(4 * x, 4 * y, 1));
        n_chk++;
        if (s_obs !== px(c)) $display("FAIL clear_pixel x=%0d y=%0d: got %h want %h", x, y, s_obs, px(c));
        else n_pass++;
      end
    wait_ec(19199);
    n_chk++; if (wf.busy !== 1'b1) $display("FAIL clear_full_busy_19199: got %b want 1", wf.busy); else n_pass++;
    wait_ec(19200);
    n_chk++; if (wf.busy !== 1'b0) $display("FAIL clear_full_busy_19200: got %b want 0", wf.busy); else n_pass++;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sync_timing();
    fill_pattern();
    test_write_origin();
    test_out_of_range();
    test_bottom_right();
    test_collision();
    test_reset_midline();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
